// File: rtl/hbridge_deadtime_drv_pkg.sv
// Shared definitions for the H-bridge gate-drive stage: state codes, gate bit
// positions and the direction encoding also used by the PWM stage.
package hbridge_deadtime_drv_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF     = 3'd0,
      ST_RUN_FWD = 3'd1,
      ST_RUN_REV = 3'd2,
      ST_BRAKE   = 3'd3,
      ST_FAULT   = 3'd4
   } hb_state_e;

   // gate_out = {AH, AL, BH, BL}
   localparam int unsigned GATE_AH = 3;
   localparam int unsigned GATE_AL = 2;
   localparam int unsigned GATE_BH = 1;
   localparam int unsigned GATE_BL = 0;

   localparam logic [1:0] DIR_FWD = 2'b10;
   localparam logic [1:0] DIR_REV = 2'b01;

   typedef struct packed {
      logic en;
      logic cmd;
   } leg_cmd_t;

   // Run state requested by a direction code; anything but FWD/REV means coast.
   function automatic hb_state_e dir_target(input logic [1:0] dir);
      case (dir)
         DIR_FWD: return ST_RUN_FWD;
         DIR_REV: return ST_RUN_REV;
         default: return ST_OFF;
      endcase
   endfunction

endpackage

// File: rtl/hb_leg_deadtime.sv
// One half-bridge leg: registered high/low FET drives with break-before-make
// dead-time. A side turns on only after en and cmd have been steady for DT_CYCLES.
module hb_leg_deadtime #(
   parameter int unsigned DT_CYCLES = 16,
   parameter int unsigned DT_W      = 8
) (
   input  logic clk_in,
   input  logic synch_reset_in,
   input  logic en,
   input  logic cmd,
   output logic hi,
   output logic lo
);

   logic [DT_W-1:0] r_timer;
   logic            r_hi;
   logic            r_lo;
   logic            r_en_q;
   logic            r_cmd_q;
   logic            w_same;

   // Any change of enable or command restarts the dead-time window.
   assign w_same = r_en_q & (r_cmd_q == cmd);

   always_ff @(posedge clk_in) begin
      if (synch_reset_in) begin
         r_hi    <= 1'b0;
         r_lo    <= 1'b0;
         r_timer <= DT_W'(DT_CYCLES);
         r_en_q  <= 1'b0;
         r_cmd_q <= 1'b0;
      end else begin
         r_en_q  <= en;
         r_cmd_q <= cmd;
         if (!en) begin
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_timer <= DT_W'(DT_CYCLES);
         end else if ((r_hi && !cmd) || (r_lo && cmd)) begin
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_timer <= DT_W'(DT_CYCLES);
         end else if (r_hi || r_lo) begin
            r_timer <= DT_W'(DT_CYCLES);
         end else if (!w_same) begin
            r_timer <= DT_W'(DT_CYCLES);
         end else if (r_timer > DT_W'(1)) begin
            r_timer <= r_timer - DT_W'(1);
         end else begin
            r_hi <= cmd;
            r_lo <= ~cmd;
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: rtl/hbridge_deadtime_drv.sv
// H-bridge gate driver: direction FSM with timed brake on reversal, sticky
// fault shutdown, and two dead-time legs whose flops drive the gate pins.
module hbridge_deadtime_drv
   import hbridge_deadtime_drv_pkg::*;
#(
   parameter int unsigned DT_CYCLES = 16,
   parameter int unsigned DT_W      = 8,
   parameter int unsigned BRAKE_CE  = 1024,
   parameter int unsigned BRAKE_W   = 16
) (
   input  logic               clk_in,
   input  logic               synch_reset_in,
   input  logic               CE_in,
   input  logic               pwm_in,
   input  logic [1:0]         dir_in,
   input  logic               fault_in,
   input  logic               fault_clear_in,
   output logic [3:0]         gate_out,
   output logic [STATE_W-1:0] state_out,
   output logic               fault_out
);

   hb_state_e          r_state;
   logic [BRAKE_W-1:0] r_brake_cnt;
   logic               r_fault;
   leg_cmd_t           w_leg_a;
   leg_cmd_t           w_leg_b;
   logic               w_a_hi;
   logic               w_a_lo;
   logic               w_b_hi;
   logic               w_b_lo;

   // Leg commands from the current state; a live fault drops both enables so
   // the gates go dark on the same edge that latches FAULT.
   always_comb begin
      w_leg_a = '0;
      w_leg_b = '0;
      case (r_state)
         ST_RUN_FWD: begin
            w_leg_a.en  = 1'b1;
            w_leg_a.cmd = pwm_in;
            w_leg_b.en  = 1'b1;
         end
         ST_RUN_REV: begin
            w_leg_a.en  = 1'b1;
            w_leg_b.en  = 1'b1;
            w_leg_b.cmd = pwm_in;
         end
         ST_BRAKE: begin
            w_leg_a.en = 1'b1;
            w_leg_b.en = 1'b1;
         end
         default: ;
      endcase
      if (fault_in) begin
         w_leg_a.en = 1'b0;
         w_leg_b.en = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (synch_reset_in) begin
         r_state     <= ST_OFF;
         r_brake_cnt <= '0;
         r_fault     <= 1'b0;
      end else if (fault_in) begin
         r_state <= ST_FAULT;
         r_fault <= 1'b1;
      end else if (CE_in) begin
         case (r_state)
            ST_OFF: r_state <= dir_target(dir_in);
            ST_RUN_FWD: begin
               if (dir_in == DIR_REV) begin
                  r_state     <= ST_BRAKE;
                  r_brake_cnt <= BRAKE_W'(BRAKE_CE);
               end else if (dir_in != DIR_FWD) begin
                  r_state <= ST_OFF;
               end
            end
            ST_RUN_REV: begin
               if (dir_in == DIR_FWD) begin
                  r_state     <= ST_BRAKE;
                  r_brake_cnt <= BRAKE_W'(BRAKE_CE);
               end else if (dir_in != DIR_REV) begin
                  r_state <= ST_OFF;
               end
            end
            // Brake length is fixed at entry; dir is only looked at on exit.
            ST_BRAKE: begin
               if (r_brake_cnt <= BRAKE_W'(1)) begin
                  r_brake_cnt <= '0;
                  r_state     <= dir_target(dir_in);
               end else begin
                  r_brake_cnt <= r_brake_cnt - BRAKE_W'(1);
               end
            end
            ST_FAULT: begin
               if (fault_clear_in) begin
                  r_state <= ST_OFF;
                  r_fault <= 1'b0;
               end
            end
            default: r_state <= ST_OFF;
         endcase
      end
   end

   hb_leg_deadtime #(
      .DT_CYCLES (DT_CYCLES),
      .DT_W      (DT_W)
   ) u_leg_a (
      .clk_in         (clk_in),
      .synch_reset_in (synch_reset_in),
      .en             (w_leg_a.en),
      .cmd            (w_leg_a.cmd),
      .hi             (w_a_hi),
      .lo             (w_a_lo)
   );

   hb_leg_deadtime #(
      .DT_CYCLES (DT_CYCLES),
      .DT_W      (DT_W)
   ) u_leg_b (
      .clk_in         (clk_in),
      .synch_reset_in (synch_reset_in),
      .en             (w_leg_b.en),
      .cmd            (w_leg_b.cmd),
      .hi             (w_b_hi),
      .lo             (w_b_lo)
   );

   always_comb begin
      gate_out          = '0;
      gate_out[GATE_AH] = w_a_hi;
      gate_out[GATE_AL] = w_a_lo;
      gate_out[GATE_BH] = w_b_hi;
      gate_out[GATE_BL] = w_b_lo;
   end

   assign state_out = r_state;
   assign fault_out = r_fault;

endmodule

// File: tb/tb_hbridge_deadtime_drv.sv
// Bench for hbridge_deadtime_drv: directed scenarios then randomized traffic,
// every cycle compared against a run-length reference model of the gate driver.
module tb_hbridge_deadtime_drv;
   import hbridge_deadtime_drv_pkg::*;

   localparam int unsigned DT  = 4;
   localparam int unsigned BCE = 8;

   logic       clk_in = 1'b0;
   logic       synch_reset_in;
   logic       CE_in;
   logic       pwm_in;
   logic [1:0] dir_in;
   logic       fault_in;
   logic       fault_clear_in;
   logic [3:0] gate_out;
   logic [2:0] state_out;
   logic       fault_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: a side is on once its leg has seen the same enabled
   // command for more than DT consecutive edges.
   logic [2:0] m_state;
   int         m_brake;
   logic       m_fault;
   int         m_run  [2];
   logic       m_pen  [2];
   logic       m_pcmd [2];
   logic [1:0] m_out  [2];

   always #5 clk_in = ~clk_in;

   hbridge_deadtime_drv #(
      .DT_CYCLES (DT),
      .DT_W      (8),
      .BRAKE_CE  (BCE),
      .BRAKE_W   (16)
   ) dut (
      .clk_in         (clk_in),
      .synch_reset_in (synch_reset_in),
      .CE_in          (CE_in),
      .pwm_in         (pwm_in),
      .dir_in         (dir_in),
      .fault_in       (fault_in),
      .fault_clear_in (fault_clear_in),
      .gate_out       (gate_out),
      .state_out      (state_out),
      .fault_out      (fault_out)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [2:0] target(input logic [1:0] d);
      if (d == 2'b10) return ST_RUN_FWD;
      if (d == 2'b01) return ST_RUN_REV;
      return ST_OFF;
   endfunction

   task automatic model_tick(input logic p, input logic [1:0] d, input logic ce,
                             input logic f, input logic clr, input logic rst);
      logic en  [2];
      logic cmd [2];
      en[0] = 1'b0; en[1] = 1'b0; cmd[0] = 1'b0; cmd[1] = 1'b0;
      if (m_state == ST_RUN_FWD) begin en[0] = 1'b1; en[1] = 1'b1; cmd[0] = p; end
      if (m_state == ST_RUN_REV) begin en[0] = 1'b1; en[1] = 1'b1; cmd[1] = p; end
      if (m_state == ST_BRAKE)   begin en[0] = 1'b1; en[1] = 1'b1; end
      for (int l = 0; l < 2; l++) begin
         if (rst || f || !en[l]) begin
            m_run[l] = 0; m_pen[l] = 1'b0; m_out[l] = 2'b00;
         end else begin
            m_run[l]  = (m_pen[l] && m_pcmd[l] == cmd[l]) ? m_run[l] + 1 : 1;
            m_pen[l]  = 1'b1;
            m_pcmd[l] = cmd[l];
            m_out[l]  = (m_run[l] > int'(DT)) ? (cmd[l] ? 2'b10 : 2'b01) : 2'b00;
         end
      end
      if (rst) begin
         m_state = ST_OFF; m_brake = 0; m_fault = 1'b0;
      end else if (f) begin
         m_state = ST_FAULT; m_fault = 1'b1;
      end else if (ce) begin
         if (m_state == ST_OFF) m_state = target(d);
         else if (m_state == ST_RUN_FWD) begin
            if (d == 2'b01) begin m_state = ST_BRAKE; m_brake = int'(BCE); end
            else if (d != 2'b10) m_state = ST_OFF;
         end else if (m_state == ST_RUN_REV) begin
            if (d == 2'b10) begin m_state = ST_BRAKE; m_brake = int'(BCE); end
            else if (d != 2'b01) m_state = ST_OFF;
         end else if (m_state == ST_BRAKE) begin
            m_brake--;
            if (m_brake == 0) m_state = target(d);
         end else if (m_state == ST_FAULT && clr) begin
            m_state = ST_OFF; m_fault = 1'b0;
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic go(input logic p, input logic [1:0] d, input logic ce,
                     input logic f, input logic clr, input logic rst);
      pwm_in = p; dir_in = d; CE_in = ce;
      fault_in = f; fault_clear_in = clr; synch_reset_in = rst;
      @(posedge clk_in);
      cyc++;
      model_tick(p, d, ce, f, clr, rst);
      #1;
      chk("gate",  8'(gate_out),  8'({m_out[0], m_out[1]}));
      chk("state", 8'(state_out), 8'(m_state));
      chk("fault", 8'(fault_out), 8'(m_fault));
      chk("no_AH_AL", 8'(gate_out[3] & gate_out[2]), 8'd0);
      chk("no_BH_BL", 8'(gate_out[1] & gate_out[0]), 8'd0);
      chk("no_AH_BH", 8'(gate_out[3] & gate_out[1]), 8'd0);
   endtask

   logic       rp;
   logic [1:0] rd;
   int         pcnt;
   int         dcnt;

   initial begin
      m_state = ST_OFF; m_brake = 0; m_fault = 1'b0;
      for (int l = 0; l < 2; l++) begin
         m_run[l] = 0; m_pen[l] = 1'b0; m_pcmd[l] = 1'b0; m_out[l] = 2'b00;
      end

      // reset
      go(0, 2'b00, 1, 0, 0, 1);
      go(0, 2'b00, 1, 0, 0, 1);
      chk("rst_gate",  8'(gate_out),  8'h0);
      chk("rst_state", 8'(state_out), 8'(ST_OFF));
      chk("rst_fault", 8'(fault_out), 8'h0);

      // forward, pwm low: both low sides after dead-time
      go(0, 2'b10, 1, 0, 0, 0);
      chk("fwd_state", 8'(state_out), 8'(ST_RUN_FWD));
      for (int k = 0; k < 8; k++) go(0, 2'b10, 1, 0, 0, 0);
      chk("fwd_low", 8'(gate_out), 8'h5);

      // pwm rise: AL off at +1, AH on at +5
      for (int k = 1; k <= 6; k++) begin
         go(1, 2'b10, 1, 0, 0, 0);
         chk("pwm_rise", 8'(gate_out), (k >= 5) ? 8'h9 : 8'h1);
      end
      for (int k = 1; k <= 10; k++) go(0, 2'b10, 1, 0, 0, 0);
      chk("pwm_fall", 8'(gate_out), 8'h5);

      // 2-cycle pulse is swallowed; AL returns at edge 7
      for (int k = 1; k <= 8; k++) begin
         go((k <= 2) ? 1'b1 : 1'b0, 2'b10, 1, 0, 0, 0);
         chk("pulse_AH", 8'(gate_out[3]), 8'h0);
         chk("pulse_AL", 8'(gate_out[2]), (k >= 7) ? 8'h1 : 8'h0);
      end

      // reversal: 8 CE ticks of brake, then leg B follows pwm
      for (int k = 0; k < 8; k++) begin
         go(0, 2'b01, 1, 0, 0, 0);
         chk("brake_state", 8'(state_out), 8'(ST_BRAKE));
         chk("brake_gate",  8'(gate_out),  8'h5);
      end
      go(0, 2'b01, 1, 0, 0, 0);
      chk("rev_state", 8'(state_out), 8'(ST_RUN_REV));
      for (int k = 1; k <= 6; k++) begin
         go(1, 2'b01, 1, 0, 0, 0);
         chk("rev_pwm", 8'(gate_out), (k >= 5) ? 8'h6 : 8'h4);
      end

      // fault with CE low, clear ignored while fault held, then cleared
      go(1, 2'b01, 0, 1, 0, 0);
      chk("flt_gate",  8'(gate_out),  8'h0);
      chk("flt_flag",  8'(fault_out), 8'h1);
      chk("flt_state", 8'(state_out), 8'(ST_FAULT));
      go(1, 2'b01, 1, 1, 1, 0);
      chk("flt_hold", 8'(state_out), 8'(ST_FAULT));
      go(1, 2'b01, 1, 0, 1, 0);
      chk("flt_clr_state", 8'(state_out), 8'(ST_OFF));
      chk("flt_clr_flag",  8'(fault_out), 8'h0);

      // reset in the middle of a brake
      go(0, 2'b10, 1, 0, 0, 0);
      go(0, 2'b00, 1, 0, 0, 0);
      go(0, 2'b10, 1, 0, 0, 0);
      for (int k = 0; k < 6; k++) go(0, 2'b10, 1, 0, 0, 0);
      go(0, 2'b01, 1, 0, 0, 0);
      go(0, 2'b01, 1, 0, 0, 0);
      go(0, 2'b01, 1, 0, 0, 0);
      chk("pre_rst_state", 8'(state_out), 8'(ST_BRAKE));
      go(0, 2'b01, 1, 0, 0, 1);
      chk("mid_rst_gate",  8'(gate_out),  8'h0);
      chk("mid_rst_state", 8'(state_out), 8'(ST_OFF));
      for (int k = 1; k <= 6; k++) begin
         go(1, 2'b10, 1, 0, 0, 0);
         chk("post_rst", 8'(gate_out), (k == 6) ? 8'h9 : 8'h0);
      end

      // randomized traffic
      rp = 1'b0; rd = 2'b10; pcnt = 0; dcnt = 0;
      for (int i = 0; i < 20000; i++) begin
         if (pcnt == 0) begin rp = ~rp; pcnt = int'($urandom_range(1, 12)); end
         else pcnt--;
         if (dcnt == 0) begin rd = 2'($urandom_range(0, 3)); dcnt = int'($urandom_range(5, 200)); end
         else dcnt--;
         go(rp, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2999) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
